// File: rtl/button_debouncer.sv
// Debounces a synchronized button level into press/release/hold pulses; BUTTON_REPEAT_EN adds auto-repeat.
// All outputs registered; press/release land DEBOUNCE_CYCLES+1 edges after the level settles; no backpressure.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic indata,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse
);

  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] D_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
`ifdef BUTTON_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t        state;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          held;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dcnt          <= '0;
      hcnt          <= '0;
      held          <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (indata) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!indata) begin
            state <= IDLE;
          end else if (dcnt == D_LAST) begin
            state       <= PRESSED;
            dcnt        <= '0;
            hcnt        <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        PRESSED: begin
          // hcnt freezes while a release is being qualified so a glitch resumes the hold timing
          if (!indata) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end else if (!held) begin
            if (hcnt == HOLD_LAST) begin
              hold_pulse <= 1'b1;
              held       <= 1'b1;
              hcnt       <= '0;
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
`ifdef BUTTON_REPEAT_EN
          else if (hcnt == REP_LAST) begin
            repeat_pulse <= 1'b1;
            hcnt         <= '0;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          if (indata) begin
            state <= PRESSED;
          end else if (dcnt == D_LAST) begin
            state         <= IDLE;
            dcnt          <= '0;
            hcnt          <= '0;
            held          <= 1'b0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BUTTON_REPEAT_EN
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE=4, HOLD=20, REPEAT=5.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;
`ifdef BUTTON_REPEAT_EN
  localparam bit REPEN = 1'b1;
`else
  localparam bit REPEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic indata;
  logic btn_level, press_pulse, release_pulse, hold_pulse, repeat_pulse;

  int total = 0;
  int bad   = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .indata(indata),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .hold_pulse(hold_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic lvl, input logic prs,
                      input logic rel, input logic hld, input logic rep);
    chk({tag, ".level"},   btn_level,     lvl);
    chk({tag, ".press"},   press_pulse,   prs);
    chk({tag, ".release"}, release_pulse, rel);
    chk({tag, ".hold"},    hold_pulse,    hld);
    chk({tag, ".repeat"},  repeat_pulse,  rep);
  endtask

  // Cycle i (1-based) drives pat[i-1]; *_at = edge index where that pulse is expected, 0 = never.
  task automatic phase(input string tag, input logic [63:0] pat, input int n,
                       input logic lvl0, input int press_at, input int rel_at,
                       input int hold_at);
    logic lvl;
    logic rep;
    lvl = lvl0;
    for (int i = 1; i <= n; i++) begin
      indata = pat[i-1];
      tick();
      if (i == press_at) lvl = 1'b1;
      if (i == rel_at)   lvl = 1'b0;
      rep = REPEN && (hold_at > 0) && (i > hold_at) && (((i - hold_at) % R) == 0);
      chk5($sformatf("%s[%0d]", tag, i), lvl, logic'(i == press_at),
           logic'(i == rel_at), logic'(i == hold_at), rep);
    end
  endtask

  initial begin
    rst    = 1'b1;
    indata = 1'b0;
    tick();
    tick();
    chk5("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // clean press: press on edge 5, hold 20 edges later, first repeat 5 after that
    phase("press", '1, 30, 1'b0, 5, 0, 25);
    phase("release", '0, 8, 1'b1, 0, 5, 0);

    // 1,1,0,1,1,1,0 never reaches five consecutive highs
    phase("bounce", 64'b0111011, 7, 1'b0, 0, 0, 0);
    phase("idle", '0, 3, 1'b0, 0, 0, 0);

    // release with glitch 0,0,1,0,0,0,0,0: final run of five zeros releases
    phase("press2", '1, 5, 1'b0, 5, 0, 0);
    phase("glitch", 64'b00000100, 8, 1'b1, 0, 8, 0);

    // long hold with repeats at +5, +10, ... when enabled
    phase("hold", '1, 55, 1'b0, 5, 0, 25);
    phase("release3", '0, 5, 1'b1, 0, 5, 0);

    // reset ten edges after press while still held
    phase("press4", '1, 15, 1'b0, 5, 0, 0);
    rst    = 1'b1;
    indata = 1'b1;
    tick();
    chk5("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    phase("after_rst", '1, 6, 1'b0, 5, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
